// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared constants and helpers for the branch target buffer
// Purpose: 2-bit predictor encodings and saturating counter update functions.
// Ports: none (package).
package btb_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not taken
  localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not taken
  localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken (allocation value)
  localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'b01;
  endfunction

endpackage

// File: rtl/btb_nway_if.sv
// rtl/btb_nway_if.sv - fetch lookup, resolve update and flush bundle of the BTB
// Purpose: groups the lookup request/response, update port and flush.
// Ports (signals): lk_valid/lk_pc, rsp_valid/rsp_hit/rsp_way/rsp_target/rsp_taken,
//   upd_valid/upd_pc/upd_target/upd_taken, flush.
//   master = pipeline side driving requests, slave = the BTB.
interface btb_nway_if #(
  parameter int PCW  = 32,
  parameter int TGTW = 32,
  parameter int WAYW = 1
);
  logic            lk_valid;
  logic [PCW-1:0]  lk_pc;
  logic            rsp_valid;
  logic            rsp_hit;
  logic [WAYW-1:0] rsp_way;
  logic [TGTW-1:0] rsp_target;
  logic            rsp_taken;
  logic            upd_valid;
  logic [PCW-1:0]  upd_pc;
  logic [TGTW-1:0] upd_target;
  logic            upd_taken;
  logic            flush;

  modport master (
    output lk_valid, lk_pc, upd_valid, upd_pc, upd_target, upd_taken, flush,
    input  rsp_valid, rsp_hit, rsp_way, rsp_target, rsp_taken
  );

  modport slave (
    input  lk_valid, lk_pc, upd_valid, upd_pc, upd_target, upd_taken, flush,
    output rsp_valid, rsp_hit, rsp_way, rsp_target, rsp_taken
  );
endinterface

// File: rtl/btb_tag_match.sv
// rtl/btb_tag_match.sv - per-set way compare with priority encoding
// Purpose: combinational valid&&tag compare across the ways of one set.
// Ports: valid  in  per-way valid bits
//        tags   in  per-way tags, way w at [w*TAGW +: TAGW]
//        tag    in  tag being searched
//        hit    out any way matched
//        way    out lowest matching way (0 on miss)
//        has_inv out some way is invalid
//        inv_way out lowest invalid way (0 if none)
module btb_tag_match #(
  parameter int WAYS = 2,
  parameter int TAGW = 27,
  parameter int WAYW = 1
) (
  input  logic [WAYS-1:0]      valid,
  input  logic [WAYS*TAGW-1:0] tags,
  input  logic [TAGW-1:0]      tag,
  output logic                 hit,
  output logic [WAYW-1:0]      way,
  output logic                 has_inv,
  output logic [WAYW-1:0]      inv_way
);

  // Scan from the highest way down so the lowest index is written last and wins.
  always_comb begin
    hit     = 1'b0;
    way     = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[w] && (tags[w*TAGW +: TAGW] == tag)) begin
        hit = 1'b1;
        way = WAYW'(w);
      end
      if (!valid[w]) begin
        has_inv = 1'b1;
        inv_way = WAYW'(w);
      end
    end
  end

endmodule

// File: rtl/btb_nway.sv
// rtl/btb_nway.sv - N-way set-associative branch target buffer
// Purpose: stores branch targets with 2-bit direction counters, answers a fetch
//   lookup one cycle later and absorbs one resolved-branch update per cycle.
// Ports: clk  in  clock
//        rst  in  synchronous active-high reset
//        bus  slave modport of btb_nway_if (lookup, response, update, flush)
module btb_nway
  import btb_pkg::*;
#(
  parameter int SETS = 8,
  parameter int WAYS = 2,
  parameter int PCW  = 32,
  parameter int TGTW = 32
) (
  input logic        clk,
  input logic        rst,
  btb_nway_if.slave  bus
);

  localparam int IDXW = $clog2(SETS);
  localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAGW = PCW - IDXW - 2;

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic [TGTW-1:0] target;
    logic [1:0]      ctr;
  } btb_entry_t;

  btb_entry_t      entries [SETS][WAYS];
  logic [WAYW-1:0] rr_ptr  [SETS];

  logic [IDXW-1:0] lk_idx, upd_idx;
  logic [TAGW-1:0] lk_tag, upd_tag;

  assign lk_idx  = bus.lk_pc[IDXW+1:2];
  assign lk_tag  = bus.lk_pc[PCW-1:IDXW+2];
  assign upd_idx = bus.upd_pc[IDXW+1:2];
  assign upd_tag = bus.upd_pc[PCW-1:IDXW+2];

  // Instruction-alignment bits never take part in indexing or tagging.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.lk_pc[1:0], bus.upd_pc[1:0]};

  logic [WAYS-1:0]      lk_vld_vec, upd_vld_vec;
  logic [WAYS*TAGW-1:0] lk_tag_vec, upd_tag_vec;

  always_comb begin
    lk_vld_vec  = '0;
    lk_tag_vec  = '0;
    upd_vld_vec = '0;
    upd_tag_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      lk_vld_vec[w]               = entries[lk_idx][w].valid;
      lk_tag_vec[w*TAGW +: TAGW]  = entries[lk_idx][w].tag;
      upd_vld_vec[w]              = entries[upd_idx][w].valid;
      upd_tag_vec[w*TAGW +: TAGW] = entries[upd_idx][w].tag;
    end
  end

  logic            lk_hit, upd_hit, upd_has_inv;
  logic [WAYW-1:0] lk_way, upd_way, upd_inv_way;
  logic            lk_unused_has_inv;
  logic [WAYW-1:0] lk_unused_inv_way;

  btb_tag_match #(.WAYS(WAYS), .TAGW(TAGW), .WAYW(WAYW)) u_lk_match (
    .valid   (lk_vld_vec),
    .tags    (lk_tag_vec),
    .tag     (lk_tag),
    .hit     (lk_hit),
    .way     (lk_way),
    .has_inv (lk_unused_has_inv),
    .inv_way (lk_unused_inv_way)
  );

  btb_tag_match #(.WAYS(WAYS), .TAGW(TAGW), .WAYW(WAYW)) u_upd_match (
    .valid   (upd_vld_vec),
    .tags    (upd_tag_vec),
    .tag     (upd_tag),
    .hit     (upd_hit),
    .way     (upd_way),
    .has_inv (upd_has_inv),
    .inv_way (upd_inv_way)
  );

  // Victim: fill a hole first; only when the set is full does round-robin choose.
  logic [WAYW-1:0] victim, rr_next;
  assign victim  = upd_has_inv ? upd_inv_way : rr_ptr[upd_idx];
  assign rr_next = (rr_ptr[upd_idx] == WAYW'(WAYS - 1)) ? '0 : rr_ptr[upd_idx] + 1'b1;

  // Response register: reads the array before this edge's update lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid  <= 1'b0;
      bus.rsp_hit    <= 1'b0;
      bus.rsp_way    <= '0;
      bus.rsp_target <= '0;
      bus.rsp_taken  <= 1'b0;
    end else begin
      bus.rsp_valid <= bus.lk_valid;
      if (bus.lk_valid && lk_hit) begin
        bus.rsp_hit    <= 1'b1;
        bus.rsp_way    <= lk_way;
        bus.rsp_target <= entries[lk_idx][lk_way].target;
        bus.rsp_taken  <= entries[lk_idx][lk_way].ctr[1];
      end else begin
        bus.rsp_hit    <= 1'b0;
        bus.rsp_way    <= '0;
        bus.rsp_target <= '0;
        bus.rsp_taken  <= 1'b0;
      end
    end
  end

  // Storage: reset clears everything, flush only valid bits and pointers
  // (counters survive), and flush swallows any concurrent update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        rr_ptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          entries[s][w] <= '0;
        end
      end
    end else if (bus.flush) begin
      for (int s = 0; s < SETS; s++) begin
        rr_ptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          entries[s][w].valid <= 1'b0;
        end
      end
    end else if (bus.upd_valid) begin
      if (upd_hit) begin
        entries[upd_idx][upd_way].target <= bus.upd_target;
        entries[upd_idx][upd_way].ctr    <= bus.upd_taken ? sat_inc(entries[upd_idx][upd_way].ctr)
                                                          : sat_dec(entries[upd_idx][upd_way].ctr);
      end else if (bus.upd_taken) begin
        entries[upd_idx][victim].valid  <= 1'b1;
        entries[upd_idx][victim].tag    <= upd_tag;
        entries[upd_idx][victim].target <= bus.upd_target;
        entries[upd_idx][victim].ctr    <= CTR_WT;
        if (!upd_has_inv) begin
          rr_ptr[upd_idx] <= rr_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_btb_nway.sv
// tb/tb_btb_nway.sv - self-checking bench for btb_nway (8 sets, 2 ways)
// Purpose: directed scenarios plus randomized traffic against a reference model.
// Ports: none (top-level bench).
module tb_btb_nway;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  btb_nway_if #(.PCW(32), .TGTW(32), .WAYW(1)) bus ();

  btb_nway #(.SETS(8), .WAYS(2), .PCW(32), .TGTW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Observed response {valid, hit, way, target, taken}
  logic [35:0] obs;
  assign obs = {bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_target, bus.rsp_taken};

  // Reference model: a table of sets, each a small list of ways.
  bit          m_valid [8][2];
  int unsigned m_tag   [8][2];
  logic [31:0] m_tgt   [8][2];
  int          m_ctr   [8][2];
  int          m_rr    [8];

  function automatic logic [35:0] mk(input logic v, input logic h, input logic w,
                                     input logic [31:0] t, input logic k);
    return {v, h, w, t, k};
  endfunction

  function automatic logic [35:0] model_lookup(input logic lv, input logic [31:0] pc);
    int s;
    int unsigned t;
    s = int'((pc >> 2) % 8);
    t = pc >> 5;
    if (!lv) return '0;
    for (int w = 0; w < 2; w++) begin
      if (m_valid[s][w] && m_tag[s][w] == t)
        return mk(1'b1, 1'b1, w[0], m_tgt[s][w], m_ctr[s][w] >= 2);
    end
    return mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endfunction

  task automatic model_apply(input logic r, input logic fl, input logic uv,
                             input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    int s;
    int unsigned t;
    int victim;
    if (r || fl) begin
      for (int i = 0; i < 8; i++) begin
        m_rr[i] = 0;
        for (int w = 0; w < 2; w++) begin
          m_valid[i][w] = 1'b0;
          if (r) m_ctr[i][w] = 0;
        end
      end
      return;
    end
    if (!uv) return;
    s = int'((pc >> 2) % 8);
    t = pc >> 5;
    for (int w = 0; w < 2; w++) begin
      if (m_valid[s][w] && m_tag[s][w] == t) begin
        m_tgt[s][w] = tgt;
        if (tk) m_ctr[s][w] = (m_ctr[s][w] < 3) ? m_ctr[s][w] + 1 : 3;
        else    m_ctr[s][w] = (m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0;
        return;
      end
    end
    if (!tk) return;
    victim = -1;
    for (int w = 0; w < 2; w++)
      if (!m_valid[s][w] && victim < 0) victim = w;
    if (victim < 0) begin
      victim  = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % 2;
    end
    m_valid[s][victim] = 1'b1;
    m_tag[s][victim]   = t;
    m_tgt[s][victim]   = tgt;
    m_ctr[s][victim]   = 2;
  endtask

  // One clock: drive inputs, predict the response from the pre-edge model,
  // then advance the model alongside the DUT.
  task automatic cycle(input logic r, input logic lv, input logic [31:0] lpc,
                       input logic uv, input logic [31:0] upc, input logic [31:0] utg,
                       input logic utk, input logic fl, output logic [35:0] exp_rsp);
    rst            = r;
    bus.lk_valid   = lv;
    bus.lk_pc      = lpc;
    bus.upd_valid  = uv;
    bus.upd_pc     = upc;
    bus.upd_target = utg;
    bus.upd_taken  = utk;
    bus.flush      = fl;
    exp_rsp = r ? 36'h0 : model_lookup(lv, lpc);
    @(posedge clk);
    #1;
    model_apply(r, fl, uv, upc, utg, utk);
  endtask

  task automatic do_reset();
    logic [35:0] e;
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, e);
  endtask

  task automatic lookup(input logic [31:0] pc, output logic [35:0] e);
    cycle(1'b0, 1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, e);
  endtask

  task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    logic [35:0] e;
    cycle(1'b0, 1'b0, 32'h0, 1'b1, pc, tgt, tk, 1'b0, e);
  endtask

  task automatic test_reset();
    logic [35:0] e;
    cycle(1'b1, 1'b1, 32'h1004, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, e);
    total++;
    if (obs !== 36'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want %h", obs, 36'h0);
    end
    lookup(32'h0000_1004, e);
    total++;
    if (obs !== mk(1, 0, 0, 32'h0, 0)) begin
      bad++;
      $display("FAIL first_lookup_miss: got %h want %h", obs, mk(1, 0, 0, 32'h0, 0));
    end
  endtask

  task automatic test_alloc_hit();
    logic [35:0] e;
    update(32'h1004, 32'h2000, 1'b1);
    lookup(32'h1004, e);
    total++;
    if (obs !== mk(1, 1, 0, 32'h2000, 1)) begin
      bad++;
      $display("FAIL alloc_hit: got %h want %h", obs, mk(1, 1, 0, 32'h2000, 1));
    end
  endtask

  task automatic test_counter();
    logic [35:0] e;
    update(32'h1004, 32'h2000, 1'b0);
    update(32'h1004, 32'h2000, 1'b0);
    lookup(32'h1004, e);
    total++;
    if (obs !== mk(1, 1, 0, 32'h2000, 0)) begin
      bad++;
      $display("FAIL ctr_two_not_taken: got %h want %h", obs, mk(1, 1, 0, 32'h2000, 0));
    end
    update(32'h1004, 32'h2000, 1'b0);
    lookup(32'h1004, e);
    total++;
    if (obs !== mk(1, 1, 0, 32'h2000, 0)) begin
      bad++;
      $display("FAIL ctr_floor: got %h want %h", obs, mk(1, 1, 0, 32'h2000, 0));
    end
    for (int i = 0; i < 4; i++) update(32'h1004, 32'h2000, 1'b1);
    lookup(32'h1004, e);
    total++;
    if (obs !== mk(1, 1, 0, 32'h2000, 1)) begin
      bad++;
      $display("FAIL ctr_four_taken: got %h want %h", obs, mk(1, 1, 0, 32'h2000, 1));
    end
    update(32'h1004, 32'h2000, 1'b0);
    lookup(32'h1004, e);
    total++;
    if (obs !== mk(1, 1, 0, 32'h2000, 1)) begin
      bad++;
      $display("FAIL ctr_ceiling: got %h want %h", obs, mk(1, 1, 0, 32'h2000, 1));
    end
  endtask

  task automatic test_replace();
    logic [35:0] e;
    do_reset();
    update(32'h0024, 32'h0000_00A0, 1'b1);
    update(32'h0044, 32'h0000_00B0, 1'b1);
    update(32'h0064, 32'h0000_00C0, 1'b1);
    lookup(32'h0024, e);
    total++;
    if (obs !== mk(1, 0, 0, 32'h0, 0)) begin
      bad++;
      $display("FAIL repl_A_evicted: got %h want %h", obs, mk(1, 0, 0, 32'h0, 0));
    end
    lookup(32'h0064, e);
    total++;
    if (obs !== mk(1, 1, 0, 32'hC0, 1)) begin
      bad++;
      $display("FAIL repl_C_way0: got %h want %h", obs, mk(1, 1, 0, 32'hC0, 1));
    end
    update(32'h0084, 32'h0000_00D0, 1'b1);
    lookup(32'h0044, e);
    total++;
    if (obs !== mk(1, 0, 0, 32'h0, 0)) begin
      bad++;
      $display("FAIL repl_B_evicted: got %h want %h", obs, mk(1, 0, 0, 32'h0, 0));
    end
    lookup(32'h0084, e);
    total++;
    if (obs !== mk(1, 1, 1, 32'hD0, 1)) begin
      bad++;
      $display("FAIL repl_D_way1: got %h want %h", obs, mk(1, 1, 1, 32'hD0, 1));
    end
  endtask

  task automatic test_same_cycle();
    logic [35:0] e;
    do_reset();
    cycle(1'b0, 1'b1, 32'h0104, 1'b1, 32'h0104, 32'h5550, 1'b1, 1'b0, e);
    total++;
    if (obs !== mk(1, 0, 0, 32'h0, 0)) begin
      bad++;
      $display("FAIL rbw_miss: got %h want %h", obs, mk(1, 0, 0, 32'h0, 0));
    end
    lookup(32'h0104, e);
    total++;
    if (obs !== mk(1, 1, 0, 32'h5550, 1)) begin
      bad++;
      $display("FAIL rbw_next_hit: got %h want %h", obs, mk(1, 1, 0, 32'h5550, 1));
    end
  endtask

  task automatic test_flush();
    logic [35:0] e;
    do_reset();
    update(32'h1004, 32'h2000, 1'b1);
    cycle(1'b0, 1'b1, 32'h1004, 1'b1, 32'h3008, 32'h7777, 1'b1, 1'b1, e);
    total++;
    if (obs !== mk(1, 1, 0, 32'h2000, 1)) begin
      bad++;
      $display("FAIL flush_cycle_lookup: got %h want %h", obs, mk(1, 1, 0, 32'h2000, 1));
    end
    lookup(32'h1004, e);
    total++;
    if (obs !== mk(1, 0, 0, 32'h0, 0)) begin
      bad++;
      $display("FAIL flush_invalidates: got %h want %h", obs, mk(1, 0, 0, 32'h0, 0));
    end
    lookup(32'h3008, e);
    total++;
    if (obs !== mk(1, 0, 0, 32'h0, 0)) begin
      bad++;
      $display("FAIL flush_drops_update: got %h want %h", obs, mk(1, 0, 0, 32'h0, 0));
    end
  endtask

  task automatic test_rst_mid();
    logic [35:0] e;
    lookup(32'h1004, e);
    total++;
    if (obs[35] !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_pre_valid: got %b want 1", obs[35]);
    end
    cycle(1'b1, 1'b1, 32'h1004, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, e);
    total++;
    if (obs !== 36'h0) begin
      bad++;
      $display("FAIL rst_mid_discard: got %h want %h", obs, 36'h0);
    end
  endtask

  task automatic test_random();
    logic [35:0] e;
    logic [31:0] lpc, upc, utg;
    logic lv, uv, tk, fl;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      lv  = ($urandom % 4) != 0;
      uv  = ($urandom % 3) != 0;
      tk  = ($urandom % 3) != 0;
      fl  = ($urandom % 50) == 0;
      lpc = (($urandom % 4) << 5) | (($urandom % 8) << 2) | ($urandom % 4);
      upc = (($urandom % 4) << 5) | (($urandom % 8) << 2) | ($urandom % 4);
      utg = $urandom;
      cycle(1'b0, lv, lpc, uv, upc, utg, tk, fl, e);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL random_cycle %0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  initial begin
    bus.lk_valid   = 1'b0;
    bus.lk_pc      = '0;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_target = '0;
    bus.upd_taken  = 1'b0;
    bus.flush      = 1'b0;
    test_reset();
    test_alloc_hit();
    test_counter();
    test_replace();
    test_same_cycle();
    test_flush();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
